cdb_arbiter: RTL and testbench

Issue scheduler for the common data bus (CDB) in the Tomasulo back end. It selects one instruction per cycle from the ready heads of the integer, load/store, multiply and divide execution queues. The selection guarantees that no two functional-unit results ever reach the CDB in the same cycle. It keeps a per-slot CDB reservation vector and publishes which unit owns the CDB each cycle, so the CDB mux downstream needs no arbitration of its own.

---
 rtl/cdb_arbiter_if.sv | 27 ++
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Request/grant bundle between the execution queues and the CDB arbiter,
// plus the published CDB owner and divider status.
interface cdb_arbiter_if;
    logic       int_req;
    logic       int_grant;
    logic       ls_req;
    logic       ls_grant;
    logic       mult_req;
    logic       mult_grant;
    logic       div_req;
    logic       div_grant;
    logic [3:0] cdb_sel;
    logic       cdb_busy;
    logic       div_busy;

    modport slave (
        input  int_req, ls_req, mult_req, div_req,
        output int_grant, ls_grant, mult_grant, div_grant,
        output cdb_sel, cdb_busy, div_busy
    );

    modport master (
        output int_req, ls_req, mult_req, div_req,
        input  int_grant, ls_grant, mult_grant, div_grant,
        input  cdb_sel, cdb_busy, div_busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB issue scheduler: one grant per cycle, CDB slots reserved ahead so results never collide.
// Grant is combinational from req (0 cycles); owner appears on cdb_sel L cycles after grant.
// Ungranted requests must be held by the queue. Optional CDB_ARB_RR_EN: round-robin int/ls.
module cdb_arbiter #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cdb_arbiter_if.slave  cdb
);

    localparam logic [1:0] OWN_INT  = 2'd0;
    localparam logic [1:0] OWN_LS   = 2'd1;
    localparam logic [1:0] OWN_MULT = 2'd2;
    localparam logic [1:0] OWN_DIV  = 2'd3;

    logic [DIV_LAT:0]       r_rsv_valid;
    logic [DIV_LAT:0][1:0]  r_rsv_owner;
    logic [3:0]             r_div_cnt;

    logic [DIV_LAT:0]       w_rsv_valid_nxt;
    logic [DIV_LAT:0][1:0]  w_rsv_owner_nxt;
    logic                   w_div_busy;
    logic                   w_int_elig;
    logic                   w_ls_elig;
    logic                   w_mult_elig;
    logic                   w_div_elig;
    logic                   w_int_gnt;
    logic                   w_ls_gnt;
    logic                   w_mult_gnt;
    logic                   w_div_gnt;

    assign w_div_busy  = (r_div_cnt != 4'd0);
    // A unit of latency L is eligible only if slot L is free, since that slot shifts to L-1.
    assign w_int_elig  = cdb.int_req  & ~r_rsv_valid[1];
    assign w_ls_elig   = cdb.ls_req   & ~r_rsv_valid[1];
    assign w_mult_elig = cdb.mult_req & ~r_rsv_valid[MULT_LAT];
    assign w_div_elig  = cdb.div_req  & ~r_rsv_valid[DIV_LAT] & ~w_div_busy;

`ifdef CDB_ARB_RR_EN
    logic r_rr_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_int_gnt) begin
            r_rr_ptr <= 1'b1;
        end else if (w_ls_gnt) begin
            r_rr_ptr <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_int_gnt  = 1'b0;
        w_ls_gnt   = 1'b0;
        w_mult_gnt = 1'b0;
        w_div_gnt  = 1'b0;
        if (!i_rst) begin
            if (w_div_elig) begin
                w_div_gnt = 1'b1;
            end else if (w_mult_elig) begin
                w_mult_gnt = 1'b1;
            end else begin
`ifdef CDB_ARB_RR_EN
                if (w_int_elig && w_ls_elig) begin
                    w_ls_gnt  = r_rr_ptr;
                    w_int_gnt = ~r_rr_ptr;
                end else begin
                    w_int_gnt = w_int_elig;
                    w_ls_gnt  = w_ls_elig;
                end
`else
                if (w_ls_elig) begin
                    w_ls_gnt = 1'b1;
                end else begin
                    w_int_gnt = w_int_elig;
                end
`endif
            end
        end
    end

    always_comb begin
        w_rsv_valid_nxt = {1'b0, r_rsv_valid[DIV_LAT:1]};
        w_rsv_owner_nxt = {2'b00, r_rsv_owner[DIV_LAT:1]};
        if (w_int_gnt) begin
            w_rsv_valid_nxt[0] = 1'b1;
            w_rsv_owner_nxt[0] = OWN_INT;
        end
        if (w_ls_gnt) begin
            w_rsv_valid_nxt[0] = 1'b1;
            w_rsv_owner_nxt[0] = OWN_LS;
        end
        if (w_mult_gnt) begin
            w_rsv_valid_nxt[MULT_LAT-1] = 1'b1;
            w_rsv_owner_nxt[MULT_LAT-1] = OWN_MULT;
        end
        if (w_div_gnt) begin
            w_rsv_valid_nxt[DIV_LAT-1] = 1'b1;
            w_rsv_owner_nxt[DIV_LAT-1] = OWN_DIV;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsv_valid <= '0;
            r_rsv_owner <= '0;
            r_div_cnt   <= 4'd0;
        end else begin
            r_rsv_valid <= w_rsv_valid_nxt;
            r_rsv_owner <= w_rsv_owner_nxt;
            if (w_div_gnt) begin
                r_div_cnt <= 4'(DIV_LAT - 1);
            end else if (w_div_busy) begin
                r_div_cnt <= r_div_cnt - 4'd1;
            end
        end
    end

    assign cdb.int_grant  = w_int_gnt;
    assign cdb.ls_grant   = w_ls_gnt;
    assign cdb.mult_grant = w_mult_gnt;
    assign cdb.div_grant  = w_div_gnt;
    assign cdb.cdb_sel    = r_rsv_valid[0] ? (4'b0001 << r_rsv_owner[0]) : 4'b0000;
    assign cdb.cdb_busy   = r_rsv_valid[0];
    assign cdb.div_busy   = w_div_busy;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter; CDB ownership checked against a scoreboard of expected slots.
module tb_cdb_arbiter;
    localparam int ML = 4;
    localparam int DL = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
    } exp_t;

    exp_t q[$];

    cdb_arbiter_if bus();

    cdb_arbiter #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .cdb   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        int idx;
        idx = -1;
        for (int i = 0; i < q.size(); i++)
            if (idx < 0 && q[i].cyc == cyc) idx = i;
        total++;
        if (idx >= 0) begin
            if (bus.cdb_sel !== q[idx].sel || bus.cdb_busy !== 1'b1) begin
                bad++;
                $display("FAIL cdb_owner cyc=%0d got sel=%b busy=%b want sel=%b busy=1",
                         cyc, bus.cdb_sel, bus.cdb_busy, q[idx].sel);
            end
            q.delete(idx);
        end else if (bus.cdb_sel !== 4'b0000 || bus.cdb_busy !== 1'b0) begin
            bad++;
            $display("FAIL cdb_idle cyc=%0d got sel=%b busy=%b want sel=0000 busy=0",
                     cyc, bus.cdb_sel, bus.cdb_busy);
        end
    end

    function automatic logic [3:0] grants();
        return {bus.div_grant, bus.mult_grant, bus.ls_grant, bus.int_grant};
    endfunction

    task automatic drive(input logic i, input logic l, input logic m, input logic d);
        bus.int_req  = i;
        bus.ls_req   = l;
        bus.mult_req = m;
        bus.div_req  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] s);
        q.push_back('{cyc: c, sel: s});
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 1);
        #2;
        total++;
        if (grants() !== 4'b0000 || bus.cdb_sel !== 4'b0000 || bus.div_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b sel=%b div_busy=%b want 0000 0000 0",
                     grants(), bus.cdb_sel, bus.div_busy);
        end
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (grants() !== 4'b0000 || bus.div_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got gnt=%b div_busy=%b want 0000 0", grants(), bus.div_busy);
        end
    endtask

    task automatic test_int_ls();
        logic [3:0] e;
        for (int k = 0; k < 6; k++) begin
            step();
            drive(1, 1, 0, 0);
            @(negedge clk);
`ifdef CDB_ARB_RR_EN
            e = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            e = 4'b0010;
`endif
            total++;
            if (grants() !== e) begin
                bad++;
                $display("FAIL int_ls k=%0d got gnt=%b want %b", k, grants(), e);
            end
            push(cyc + 1, e);
        end
        step();
        idle(10);
    endtask

    task automatic test_int_stream();
        for (int k = 0; k < 5; k++) begin
            step();
            drive(1, 0, 0, 0);
            @(negedge clk);
            total++;
            if (grants() !== 4'b0001) begin
                bad++;
                $display("FAIL int_stream k=%0d got gnt=%b want 0001", k, grants());
            end
            push(cyc + 1, 4'b0001);
        end
        step();
        idle(10);
    endtask

    task automatic test_div_int();
        step();
        drive(1, 0, 0, 1);
        @(negedge clk);
        total++;
        if (grants() !== 4'b1000) begin
            bad++;
            $display("FAIL div_over_int got gnt=%b want 1000", grants());
        end
        push(cyc + DL, 4'b1000);
        step();
        drive(1, 0, 0, 0);
        @(negedge clk);
        total++;
        if (grants() !== 4'b0001 || bus.div_busy !== 1'b1) begin
            bad++;
            $display("FAIL int_after_div got gnt=%b div_busy=%b want 0001 1", grants(), bus.div_busy);
        end
        push(cyc + 1, 4'b0001);
        step();
        idle(12);
    endtask

    task automatic test_mult_block();
        step();
        drive(0, 0, 1, 0);
        @(negedge clk);
        total++;
        if (grants() !== 4'b0100) begin
            bad++;
            $display("FAIL mult_grant got gnt=%b want 0100", grants());
        end
        push(cyc + ML, 4'b0100);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        drive(1, 0, 0, 0);
        @(negedge clk);
        total++;
        if (grants() !== 4'b0000) begin
            bad++;
            $display("FAIL int_blocked got gnt=%b want 0000", grants());
        end
        step();
        @(negedge clk);
        total++;
        if (grants() !== 4'b0001) begin
            bad++;
            $display("FAIL int_unblocked got gnt=%b want 0001", grants());
        end
        push(cyc + 1, 4'b0001);
        step();
        idle(10);
    endtask

    task automatic test_div_back_to_back();
        logic [3:0] e;
        logic       eb;
        for (int k = 0; k < 16; k++) begin
            step();
            drive(0, 0, 0, 1);
            @(negedge clk);
            e  = (k % DL == 0) ? 4'b1000 : 4'b0000;
            eb = (k % DL != 0);
            total++;
            if (grants() !== e || bus.div_busy !== eb) begin
                bad++;
                $display("FAIL div_b2b k=%0d got gnt=%b busy=%b want %b %b", k, grants(), bus.div_busy, e, eb);
            end
            if (e != 4'b0000) push(cyc + DL, 4'b1000);
        end
        step();
        idle(12);
    endtask

    task automatic test_mult_stream();
        logic [3:0] e;
        for (int k = 0; k < 8; k++) begin
            step();
            drive(0, 1, k < 4, 0);
            @(negedge clk);
            e = (k < 4) ? 4'b0100 : ((k == 7) ? 4'b0010 : 4'b0000);
            total++;
            if (grants() !== e) begin
                bad++;
                $display("FAIL mult_stream k=%0d got gnt=%b want %b", k, grants(), e);
            end
            if (e == 4'b0100) push(cyc + ML, e);
            if (e == 4'b0010) push(cyc + 1, e);
        end
        step();
        idle(10);
    endtask

    task automatic test_mid_reset();
        logic [3:0] e;
        step();
        drive(0, 0, 1, 0);
        @(negedge clk);
        total++;
        if (grants() !== 4'b0100) begin
            bad++;
            $display("FAIL pre_reset_mult got gnt=%b want 0100", grants());
        end
        step();
        drive(0, 0, 0, 0);
        step();
        drive(1, 1, 1, 1);
        rst = 1'b1;
        #1;
        total++;
        if (grants() !== 4'b0000 || bus.cdb_sel !== 4'b0000 || bus.cdb_busy !== 1'b0 || bus.div_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got gnt=%b sel=%b busy=%b div_busy=%b want all 0",
                     grants(), bus.cdb_sel, bus.cdb_busy, bus.div_busy);
        end
        @(negedge clk);
        total++;
        if (grants() !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold got gnt=%b want 0000", grants());
        end
        step();
        drive(0, 0, 0, 0);
        rst = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (bus.cdb_sel !== 4'b0000) begin
            bad++;
            $display("FAIL flushed_mult got sel=%b want 0000", bus.cdb_sel);
        end
        step();
        drive(1, 1, 0, 0);
        @(negedge clk);
`ifdef CDB_ARB_RR_EN
        e = 4'b0001;
`else
        e = 4'b0010;
`endif
        total++;
        if (grants() !== e) begin
            bad++;
            $display("FAIL post_reset_grant got gnt=%b want %b", grants(), e);
        end
        push(cyc + 1, e);
        step();
        idle(10);
    endtask

    task automatic test_rr_hold();
        step();
        drive(0, 0, 1, 0);
        @(negedge clk);
        push(cyc + ML, 4'b0100);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        drive(1, 1, 0, 0);
        @(negedge clk);
        total++;
        if (grants() !== 4'b0000) begin
            bad++;
            $display("FAIL both_blocked got gnt=%b want 0000", grants());
        end
        step();
        @(negedge clk);
        total++;
        if (grants() !== 4'b0010) begin
            bad++;
            $display("FAIL rr_hold got gnt=%b want 0010", grants());
        end
        push(cyc + 1, 4'b0010);
        step();
        idle(10);
    endtask

    initial begin
        test_reset();
        test_int_ls();
        test_int_stream();
        test_div_int();
        test_mult_block();
        test_div_back_to_back();
        test_mult_stream();
        test_mid_reset();
        test_rr_hold();
        idle(4);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
